// File: rtl/reg_scoreboard.sv
// Register scoreboard beside the decode stage: tracks in-flight destination registers
// (fixed-latency countdowns and variable-latency ops retired via cpl_*) and flags hazards.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int LAT_W    = 3,
    parameter int MAX_VAR  = 2,
    parameter int VW       = $clog2(MAX_VAR + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic                id_advance,
    input  logic [AW-1:0]       id_rs1,
    input  logic [AW-1:0]       id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [AW-1:0]       id_rd,
    input  logic                id_wen,
    input  logic                id_var,
    input  logic [LAT_W-1:0]    id_lat,
    input  logic                cpl_valid,
    input  logic [AW-1:0]       cpl_rd,
    output logic                stall,
    output logic                stall_raw,
    output logic                stall_waw,
    output logic                stall_struct,
    output logic                fire,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [VW-1:0]       var_cnt,
    output logic                cpl_err
);

    logic [LAT_W-1:0]    cnt      [NUM_REGS];
    logic [LAT_W-1:0]    cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] var_pend;
    logic [NUM_REGS-1:0] var_pend_next;
    logic [VW-1:0]       var_cnt_next;
    logic                rs1_ready;
    logic                rs2_ready;
    logic                wr;
    logic                fix_issue;
    logic                var_issue;
    logic                var_retire;

    assign rs1_ready = (id_rs1 == '0) || ((cnt[id_rs1] == '0) && !var_pend[id_rs1]);
    assign rs2_ready = (id_rs2 == '0) || ((cnt[id_rs2] == '0) && !var_pend[id_rs2]);
    assign wr        = id_wen && (id_rd != '0);

    assign stall_raw    = id_valid && ((id_rs1_used && !rs1_ready) || (id_rs2_used && !rs2_ready));
    assign stall_waw    = id_valid && wr && var_pend[id_rd];
    assign stall_struct = id_valid && wr && id_var && (var_cnt == VW'(MAX_VAR));
    assign stall        = stall_raw || stall_waw || stall_struct;
    assign fire         = id_valid && id_advance && !stall;

    assign fix_issue  = fire && wr && !id_var;
    assign var_issue  = fire && wr && id_var;
    assign var_retire = cpl_valid && var_pend[cpl_rd];

    // A new fixed producer never shortens an older, longer countdown on the same register.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_next[r] = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
            if ((r != 0) && fix_issue && (id_rd == AW'(r)) && (id_lat > cnt_next[r])) begin
                cnt_next[r] = id_lat;
            end
        end
    end

    always_comb begin
        var_pend_next = var_pend;
        if (var_retire) begin
            var_pend_next[cpl_rd] = 1'b0;
        end
        if (var_issue) begin
            var_pend_next[id_rd] = 1'b1;
        end
        var_pend_next[0] = 1'b0;
    end

    always_comb begin
        var_cnt_next = var_cnt;
        case ({var_issue, var_retire})
            2'b10:   var_cnt_next = var_cnt + VW'(1);
            2'b01:   var_cnt_next = var_cnt - VW'(1);
            default: var_cnt_next = var_cnt;
        endcase
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0) || var_pend[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            var_pend <= '0;
            var_cnt  <= '0;
            cpl_err  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_next[r];
            end
            var_pend <= var_pend_next;
            var_cnt  <= var_cnt_next;
            cpl_err  <= cpl_valid && !var_pend[cpl_rd];
        end
    end

endmodule
